// File: rtl/twiddle_cmul_stage3_pkg.sv
// ----------------------------------------------------------------------------
// twiddle_cmul_stage3_pkg
// Shared definitions for the FFT stage-3 twiddle complex-multiply slice.
//   - Default widths (DW, AW, TW_DEPTH)
//   - Q8.8 fixed-point constants used by the round/saturate path
//   - Signed complex-sample typedef
//   - Small helper functions used by the datapath
// ----------------------------------------------------------------------------
package twiddle_cmul_stage3_pkg;

   localparam int DW_DEF       = 16;
   localparam int AW_DEF       = 5;
   localparam int TW_DEPTH_DEF = 28;

   // Q8.8 format
   localparam int                FRAC_BITS   = 8;
   localparam logic [DW_DEF-1:0] ROUND_CONST = 16'h0080;
   localparam logic [DW_DEF-1:0] SAT_MAX     = 16'h7FFF;
   localparam logic [DW_DEF-1:0] SAT_MIN     = 16'h8000;

   typedef struct packed {
      logic signed [DW_DEF-1:0] re;
      logic signed [DW_DEF-1:0] im;
   } cplx_t;

   // Sign-extend a 2*DW_DEF product by one bit so that a sum or difference
   // of two products cannot overflow.
   function automatic logic [2*DW_DEF:0] sext_prod(input logic [2*DW_DEF-1:0] p);
      return {p[2*DW_DEF-1], p};
   endfunction

   // True when every bit of the guard field matches, i.e. the value
   // fits in the narrower signed destination without clipping.
   function automatic logic guard_ok(input logic [DW_DEF+2:0] g);
      return (&g) | (~|g);
   endfunction

endpackage

// File: rtl/q88_round_sat.sv
// ----------------------------------------------------------------------------
// q88_round_sat
// Combinational Q8.8 rescale: takes a signed 2*DW+1-bit product sum (Q16.16
// scale), adds half an output LSB (round half up), shifts right by the
// fraction width and clips the result to the signed DW-bit range.
// Ports:
//   sum  in   2*DW+1  signed sum of two Q8.8 x Q8.8 products
//   res  out  DW      rounded, saturated Q8.8 result
// The saturation constants come from the package and assume DW == DW_DEF.
// ----------------------------------------------------------------------------
module q88_round_sat
   import twiddle_cmul_stage3_pkg::*;
#(
   parameter int DW = DW_DEF
) (
   input  logic signed [2*DW:0]   sum,
   output logic signed [DW-1:0]   res
);

   localparam logic [2*DW+1:0] RND_EXT = (2*DW+2)'(ROUND_CONST);

   logic signed [2*DW+1:0] rnd_s;
   logic signed [2*DW+1:0] shf_s;

   // Round, shift and clip. One extra bit of headroom keeps the +0x80
   // from wrapping at the top of the range; the arithmetic shift keeps sign.
   always_comb begin
      rnd_s = {sum[2*DW], sum} + RND_EXT;
      shf_s = rnd_s >>> FRAC_BITS;
      if (guard_ok(shf_s[2*DW+1:DW-1])) begin
         res = shf_s[DW-1:0];
      end else if (shf_s[2*DW+1]) begin
         res = DW'(SAT_MIN);
      end else begin
         res = DW'(SAT_MAX);
      end
   end

endmodule

// File: rtl/twiddle_cmul_stage3.sv
// ----------------------------------------------------------------------------
// twiddle_cmul_stage3
// Streaming complex multiply for FFT stage 3. Each valid input sample is
// multiplied by the twiddle at the current frame address; the result is
// rounded and saturated back to Q8.8. Three-edge latency, one sample/cycle.
// Ports:
//   clk         in   1   system clock, rising edge
//   rst_n       in   1   asynchronous active-low reset
//   clr         in   1   synchronous frame restart (counter to 0, valids flushed)
//   in_valid    in   1   input sample valid
//   in_re/im    in   DW  input sample, signed Q8.8
//   tw_addr     out  AW  address to both twiddle ROMs (combinational from counter)
//   tw_re/im    in   DW  twiddle ROM data, valid one cycle after tw_addr
//   out_valid   out  1   result valid
//   out_re/im   out  DW  result, Q8.8, held while out_valid is low
//   frame_done  out  1   pulse with the result of frame address TW_DEPTH-1
// ----------------------------------------------------------------------------
module twiddle_cmul_stage3
   import twiddle_cmul_stage3_pkg::*;
#(
   parameter int DW       = DW_DEF,
   parameter int AW       = AW_DEF,
   parameter int TW_DEPTH = TW_DEPTH_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clr,
   input  logic                 in_valid,
   input  logic signed [DW-1:0] in_re,
   input  logic signed [DW-1:0] in_im,
   output logic [AW-1:0]        tw_addr,
   input  logic signed [DW-1:0] tw_re,
   input  logic signed [DW-1:0] tw_im,
   output logic                 out_valid,
   output logic signed [DW-1:0] out_re,
   output logic signed [DW-1:0] out_im,
   output logic                 frame_done
);

   localparam logic [AW-1:0] LAST_ADDR = AW'(TW_DEPTH - 1);
   localparam logic [AW-1:0] ADDR_ONE  = {{(AW-1){1'b0}}, 1'b1};

   logic [AW-1:0]          cnt_r;
   cplx_t                  s0_smp_r;
   logic                   s0_vld_r;
   logic                   s0_last_r;
   logic signed [2*DW-1:0] pr_r;
   logic signed [2*DW-1:0] pi_r;
   logic signed [2*DW-1:0] qr_r;
   logic signed [2*DW-1:0] qi_r;
   logic                   s1_vld_r;
   logic                   s1_last_r;
   logic signed [2*DW:0]   sum_re_s;
   logic signed [2*DW:0]   sum_im_s;
   logic signed [DW-1:0]   rs_re_s;
   logic signed [DW-1:0]   rs_im_s;
   logic                   cnt_last_s;

   // The ROM samples the address on the same edge that captures the sample,
   // so the address is the counter itself with no extra register.
   assign tw_addr    = cnt_r;
   assign cnt_last_s = (cnt_r == LAST_ADDR);

   // Twiddle address counter: advances per accepted sample, wraps at frame end.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= {AW{1'b0}};
      end else if (clr) begin
         cnt_r <= {AW{1'b0}};
      end else if (in_valid) begin
         cnt_r <= cnt_last_s ? {AW{1'b0}} : (cnt_r + ADDR_ONE);
      end else begin
         cnt_r <= cnt_r;
      end
   end

   // Stage S0: capture the sample and tag the last address of the frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s0_smp_r  <= {(2*DW){1'b0}};
         s0_vld_r  <= 1'b0;
         s0_last_r <= 1'b0;
      end else if (clr) begin
         s0_smp_r  <= s0_smp_r;
         s0_vld_r  <= 1'b0;
         s0_last_r <= 1'b0;
      end else begin
         s0_vld_r  <= in_valid;
         s0_last_r <= in_valid & cnt_last_s;
         if (in_valid) begin
            s0_smp_r.re <= in_re;
            s0_smp_r.im <= in_im;
         end else begin
            s0_smp_r <= s0_smp_r;
         end
      end
   end

   // Stage S1: ROM data is valid now; form the four partial products.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pr_r      <= {(2*DW){1'b0}};
         pi_r      <= {(2*DW){1'b0}};
         qr_r      <= {(2*DW){1'b0}};
         qi_r      <= {(2*DW){1'b0}};
         s1_vld_r  <= 1'b0;
         s1_last_r <= 1'b0;
      end else if (clr) begin
         s1_vld_r  <= 1'b0;
         s1_last_r <= 1'b0;
      end else begin
         s1_vld_r  <= s0_vld_r;
         s1_last_r <= s0_last_r;
         if (s0_vld_r) begin
            pr_r <= $signed(s0_smp_r.re) * tw_re;
            pi_r <= $signed(s0_smp_r.im) * tw_im;
            qr_r <= $signed(s0_smp_r.re) * tw_im;
            qi_r <= $signed(s0_smp_r.im) * tw_re;
         end else begin
            pr_r <= pr_r;
            pi_r <= pi_r;
            qr_r <= qr_r;
            qi_r <= qi_r;
         end
      end
   end

   // Combine products with one bit of growth so the sums never wrap.
   always_comb begin
      sum_re_s = sext_prod(pr_r) - sext_prod(pi_r);
      sum_im_s = sext_prod(qr_r) + sext_prod(qi_r);
   end

   q88_round_sat #(.DW(DW)) u_rs_re (
      .sum (sum_re_s),
      .res (rs_re_s)
   );

   q88_round_sat #(.DW(DW)) u_rs_im (
      .sum (sum_im_s),
      .res (rs_im_s)
   );

   // Stage S2: register the rescaled result; data holds between valids.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_re     <= {DW{1'b0}};
         out_im     <= {DW{1'b0}};
         out_valid  <= 1'b0;
         frame_done <= 1'b0;
      end else if (clr) begin
         out_valid  <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         out_valid  <= s1_vld_r;
         frame_done <= s1_vld_r & s1_last_r;
         if (s1_vld_r) begin
            out_re <= rs_re_s;
            out_im <= rs_im_s;
         end else begin
            out_re <= out_re;
            out_im <= out_im;
         end
      end
   end

endmodule

// File: tb/tb_twiddle_cmul_stage3.sv
// ----------------------------------------------------------------------------
// tb_twiddle_cmul_stage3
// Directed bench for twiddle_cmul_stage3. The bench plays the twiddle ROMs
// (one-cycle synchronous read). Inputs change and outputs are sampled on the
// falling edge; a sample driven at one falling edge appears three falling
// edges later.
// ----------------------------------------------------------------------------
module tb_twiddle_cmul_stage3;

   logic               clk;
   logic               rst_n;
   logic               clr;
   logic               in_valid;
   logic signed [15:0] in_re;
   logic signed [15:0] in_im;
   logic [4:0]         tw_addr;
   logic signed [15:0] tw_re;
   logic signed [15:0] tw_im;
   logic               out_valid;
   logic signed [15:0] out_re;
   logic signed [15:0] out_im;
   logic               frame_done;

   logic [15:0] rom_re [0:31];
   logic [15:0] rom_im [0:31];

   int checks = 0;
   int errors = 0;

   twiddle_cmul_stage3 dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr        (clr),
      .in_valid   (in_valid),
      .in_re      (in_re),
      .in_im      (in_im),
      .tw_addr    (tw_addr),
      .tw_re      (tw_re),
      .tw_im      (tw_im),
      .out_valid  (out_valid),
      .out_re     (out_re),
      .out_im     (out_im),
      .frame_done (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ROM model: synchronous read, one cycle latency
   always @(posedge clk) begin
      tw_re <= rom_re[tw_addr];
      tw_im <= rom_im[tw_addr];
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, expected bench to finish");
      $fatal(1);
   end

   task automatic rom_const(input logic [15:0] r, input logic [15:0] i);
      for (int a = 0; a < 32; a++) begin
         rom_re[a] = r;
         rom_im[a] = i;
      end
   endtask

   // rom_re[a] = (a+1).0 so the result reveals which address was used
   task automatic rom_ramp(input logic [15:0] i);
      for (int a = 0; a < 32; a++) begin
         rom_re[a] = 16'((a + 1) * 256);
         rom_im[a] = i;
      end
   endtask

   task automatic do_clr();
      @(negedge clk);
      clr = 1'b1;
      in_valid = 1'b0;
      @(negedge clk);
      clr = 1'b0;
   endtask

   task automatic send_one(input logic [15:0] re, input logic [15:0] im,
                           output logic [4:0] addr_o, output logic early_v,
                           output logic v, output logic [15:0] ore,
                           output logic [15:0] oim, output logic fd);
      @(negedge clk);
      addr_o = tw_addr;
      in_valid = 1'b1;
      in_re = re;
      in_im = im;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      early_v = out_valid;
      @(negedge clk);
      v = out_valid;
      ore = out_re;
      oim = out_im;
      fd = frame_done;
   endtask

   task automatic test_reset();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      checks++; if (out_re !== 16'h0000) begin errors++; $display("FAIL reset_out_re: got %h expected 0000", out_re); end
      checks++; if (out_im !== 16'h0000) begin errors++; $display("FAIL reset_out_im: got %h expected 0000", out_im); end
      checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
      checks++; if (tw_addr !== 5'd0) begin errors++; $display("FAIL reset_tw_addr: got %0d expected 0", tw_addr); end
   endtask

   task automatic test_identity();
      logic [4:0] a; logic ev, v, fd; logic [15:0] r, i;
      rom_const(16'h0100, 16'h0000);
      do_clr();
      send_one(16'h0200, 16'h0100, a, ev, v, r, i, fd);
      checks++; if (a !== 5'd0) begin errors++; $display("FAIL ident_addr: got %0d expected 0", a); end
      checks++; if (ev !== 1'b0) begin errors++; $display("FAIL ident_latency_early: got %b expected 0", ev); end
      checks++; if (v !== 1'b1) begin errors++; $display("FAIL ident_valid: got %b expected 1", v); end
      checks++; if (r !== 16'h0200) begin errors++; $display("FAIL ident_re: got %h expected 0200", r); end
      checks++; if (i !== 16'h0100) begin errors++; $display("FAIL ident_im: got %h expected 0100", i); end
      checks++; if (fd !== 1'b0) begin errors++; $display("FAIL ident_frame_done: got %b expected 0", fd); end
   endtask

   task automatic test_rotate();
      logic [4:0] a; logic ev, v, fd; logic [15:0] r, i;
      rom_const(16'h0000, 16'h0100);
      do_clr();
      send_one(16'h0100, 16'h0000, a, ev, v, r, i, fd);
      checks++; if (v !== 1'b1) begin errors++; $display("FAIL rot_valid: got %b expected 1", v); end
      checks++; if (r !== 16'h0000) begin errors++; $display("FAIL rot_re: got %h expected 0000", r); end
      checks++; if (i !== 16'h0100) begin errors++; $display("FAIL rot_im: got %h expected 0100", i); end
   endtask

   task automatic test_round();
      logic [4:0] a; logic ev, v, fd; logic [15:0] r, i;
      rom_const(16'h0080, 16'h0000);
      do_clr();
      send_one(16'h0001, 16'h0000, a, ev, v, r, i, fd);
      checks++; if (r !== 16'h0001) begin errors++; $display("FAIL round_pos_half: got %h expected 0001", r); end
      checks++; if (i !== 16'h0000) begin errors++; $display("FAIL round_pos_im: got %h expected 0000", i); end
      send_one(16'hFFFF, 16'h0000, a, ev, v, r, i, fd);
      checks++; if (r !== 16'h0000) begin errors++; $display("FAIL round_neg_half: got %h expected 0000", r); end
      checks++; if (v !== 1'b1) begin errors++; $display("FAIL round_valid: got %b expected 1", v); end
   endtask

   task automatic test_saturate();
      logic [4:0] a; logic ev, v, fd; logic [15:0] r, i;
      rom_const(16'h0100, 16'h0100);
      do_clr();
      send_one(16'h7FFF, 16'h8000, a, ev, v, r, i, fd);
      checks++; if (r !== 16'h7FFF) begin errors++; $display("FAIL sat_pos_re: got %h expected 7fff", r); end
      checks++; if (i !== 16'hFFFF) begin errors++; $display("FAIL sat_pos_im: got %h expected ffff", i); end
      send_one(16'h8000, 16'h7FFF, a, ev, v, r, i, fd);
      checks++; if (r !== 16'h8000) begin errors++; $display("FAIL sat_neg_re: got %h expected 8000", r); end
      checks++; if (i !== 16'hFFFF) begin errors++; $display("FAIL sat_neg_im: got %h expected ffff", i); end
   endtask

   // 30 back-to-back samples: address wraps after 27, frame_done on the 28th result
   task automatic test_back_to_back();
      int k;
      logic [15:0] exp_re;
      rom_ramp(16'h0000);
      do_clr();
      for (int n = 0; n < 34; n++) begin
         @(negedge clk);
         if (n < 30) begin
            checks++;
            if (tw_addr !== 5'(n % 28)) begin errors++; $display("FAIL b2b_addr[%0d]: got %0d expected %0d", n, tw_addr, n % 28); end
         end
         k = n - 3;
         if (k >= 0 && k < 30) begin
            exp_re = 16'(((k % 28) + 1) * 256);
            checks++;
            if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d]: got %b expected 1", k, out_valid); end
            checks++;
            if (out_re !== exp_re) begin errors++; $display("FAIL b2b_re[%0d]: got %h expected %h", k, out_re, exp_re); end
            checks++;
            if (frame_done !== ((k % 28) == 27)) begin errors++; $display("FAIL b2b_frame_done[%0d]: got %b expected %b", k, frame_done, (k % 28) == 27); end
         end else begin
            checks++;
            if (out_valid !== 1'b0 || frame_done !== 1'b0) begin errors++; $display("FAIL b2b_idle[%0d]: got valid %b done %b expected 0 0", n, out_valid, frame_done); end
         end
         in_valid = (n < 30);
         in_re = 16'h0100;
         in_im = 16'h0000;
      end
      in_valid = 1'b0;
   endtask

   task automatic test_gaps();
      logic vin [0:6];
      logic exp_v;
      vin = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      rom_ramp(16'h0000);
      do_clr();
      for (int n = 0; n < 7; n++) begin
         @(negedge clk);
         if (n == 0 || n == 2) begin
            checks++;
            if (tw_addr !== 5'(n / 2)) begin errors++; $display("FAIL gap_addr[%0d]: got %0d expected %0d", n, tw_addr, n / 2); end
         end
         exp_v = 1'b0;
         if (n >= 3) exp_v = vin[n-3];
         checks++;
         if (out_valid !== exp_v) begin errors++; $display("FAIL gap_valid[%0d]: got %b expected %b", n, out_valid, exp_v); end
         if (n == 3 || n == 4) begin
            checks++;
            if (out_re !== 16'h0100) begin errors++; $display("FAIL gap_re_hold[%0d]: got %h expected 0100", n, out_re); end
         end
         if (n == 5) begin
            checks++;
            if (out_re !== 16'h0200) begin errors++; $display("FAIL gap_re_addr1: got %h expected 0200", out_re); end
         end
         in_valid = vin[n];
         in_re = 16'h0100;
         in_im = 16'h0000;
      end
   endtask

   task automatic test_clr();
      rom_ramp(16'h0000);
      do_clr();
      for (int n = 0; n < 10; n++) begin
         @(negedge clk);
         if (n >= 6 && n <= 8) begin
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL clr_stale_valid[%0d]: got %b expected 0", n, out_valid); end
         end
         if (n == 6) begin
            checks++;
            if (tw_addr !== 5'd0) begin errors++; $display("FAIL clr_addr: got %0d expected 0", tw_addr); end
         end
         if (n == 9) begin
            checks++;
            if (out_valid !== 1'b1) begin errors++; $display("FAIL clr_new_valid: got %b expected 1", out_valid); end
            checks++;
            if (out_re !== 16'h0100) begin errors++; $display("FAIL clr_new_re: got %h expected 0100", out_re); end
         end
         clr = (n == 5);
         in_valid = (n <= 6);
         in_re = 16'h0100;
         in_im = 16'h0000;
      end
      clr = 1'b0;
      in_valid = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic [4:0] a; logic ev, v, fd; logic [15:0] r, i;
      rom_ramp(16'h0100);
      do_clr();
      for (int n = 0; n < 5; n++) begin
         @(negedge clk);
         in_valid = (n < 4);
         in_re = 16'h0100;
         in_im = 16'h0000;
      end
      checks++; if (out_valid !== 1'b1 || out_re !== 16'h0200) begin errors++; $display("FAIL rstmid_pre: got valid %b re %h expected 1 0200", out_valid, out_re); end
      rst_n = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b expected 0", out_valid); end
      checks++; if (out_re !== 16'h0000 || out_im !== 16'h0000) begin errors++; $display("FAIL rstmid_data: got %h %h expected 0000 0000", out_re, out_im); end
      checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL rstmid_frame_done: got %b expected 0", frame_done); end
      checks++; if (tw_addr !== 5'd0) begin errors++; $display("FAIL rstmid_addr: got %0d expected 0", tw_addr); end
      @(negedge clk);
      rst_n = 1'b1;
      send_one(16'h0100, 16'h0000, a, ev, v, r, i, fd);
      checks++; if (a !== 5'd0) begin errors++; $display("FAIL rstmid_restart_addr: got %0d expected 0", a); end
      checks++; if (ev !== 1'b0 || v !== 1'b1) begin errors++; $display("FAIL rstmid_restart_valid: got %b%b expected 01", ev, v); end
      checks++; if (r !== 16'h0100 || i !== 16'h0100) begin errors++; $display("FAIL rstmid_restart_data: got %h %h expected 0100 0100", r, i); end
   endtask

   initial begin
      rst_n = 1'b0;
      clr = 1'b0;
      in_valid = 1'b0;
      in_re = 16'h0000;
      in_im = 16'h0000;
      rom_const(16'h0100, 16'h0000);
      #12;
      test_reset();
      @(negedge clk);
      rst_n = 1'b1;
      test_identity();
      test_rotate();
      test_round();
      test_saturate();
      test_back_to_back();
      test_gaps();
      test_clr();
      test_reset_mid();
      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/twiddle_cmul_stage3.md
Name: twiddle_cmul_stage3

Overview:
Streaming complex-multiply stage for FFT stage 3.
- Sequences the 5-bit twiddle address into the stage-3 real and imaginary twiddle ROMs.
- Absorbs the ROMs' 1-cycle synchronous read latency.
- Multiplies each incoming butterfly sample by its twiddle (Q8.8) and emits a rounded, saturated Q8.8 complex result.
- Sits between the stage-3 butterfly output and the stage-4 input.

Parameters:
DW, 16, sample and twiddle width (signed Q8.8)
AW, 5, twiddle ROM address width
TW_DEPTH, 28, twiddle entries used per frame (addresses 0..TW_DEPTH-1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
clr  in  1  synchronous frame restart; address counter to 0, pipeline valids flushed
in_valid  in  1  input sample valid
in_re  in  DW  input real part, signed Q8.8
in_im  in  DW  input imaginary part, signed Q8.8
tw_addr  out  AW  address driven to both twiddle ROMs
tw_re  in  DW  real twiddle ROM data, valid 1 cycle after tw_addr
tw_im  in  DW  imaginary twiddle ROM data, valid 1 cycle after tw_addr
out_valid  out  1  result valid
out_re  out  DW  result real part, Q8.8
out_im  out  DW  result imaginary part, Q8.8
frame_done  out  1  1-cycle pulse coincident with out_valid of the last sample in a frame (address TW_DEPTH-1)

Behaviour:
- Reset (rst_n low, asynchronous): addr counter=0, tw_addr=0, all pipeline valids=0, out_valid=0, out_re=out_im=0, frame_done=0.
- tw_addr is combinational from the addr counter; the ROM samples it on the same edge that registers the input sample.
- Stage S0 (edge 1): when in_valid=1, register in_re/in_im, valid, last flag (counter==TW_DEPTH-1); increment the counter. If the counter is at TW_DEPTH-1, wrap it to 0. The counter holds when in_valid=0.
- Stage S1 (edge 2): ROM data is now valid. Register the four signed 2*DW products: pr=in_re*tw_re, pi=in_im*tw_im, qr=in_re*tw_im, qi=in_im*tw_re.
- Stage S2 (edge 3): sum_re=pr-pi and sum_im=qr+qi, each 2*DW+1 bits signed.
  - Add 0x80 (round half up), then arithmetic shift right by 8.
  - Saturate to [0x8000,0x7FFF]; register to out_re/out_im.
  - out_valid and frame_done are registered alongside.
- Latency: in_valid to out_valid is exactly 3 clock edges. Throughput is 1 sample/cycle. Gaps in in_valid propagate as gaps in out_valid.
- out_re/out_im hold their last value when out_valid=0.
- No backpressure; the downstream stage must accept every out_valid.
- clr=1: counter to 0, S0/S1/S2 valids and frame_done to 0 next edge. A sample presented with in_valid in the same cycle is dropped.
- clr has priority over in_valid. Reset mid-frame behaves like clr, but asynchronously and with data registers also zeroed.
- Counter never exceeds TW_DEPTH-1; addresses TW_DEPTH..31 are never driven.

Decomposition:
- Shared package holds:
  - Q8.8 format constants: fraction bits = 8, ROUND_CONST = 0x80, SAT_MAX = 0x7FFF, SAT_MIN = 0x8000.
  - DW, AW, TW_DEPTH defaults.
  - A signed complex-sample typedef (re/im DW each).
- One sub-module: q88_round_sat, a combinational function that takes a 2*DW+1 signed sum and returns a rounded, saturated DW result. It is instantiated twice, for the real and imaginary paths.
- The counter and the pipeline stay in the top module.

Test Plan:
- Identity twiddle: the ROM model returns tw_re=0x0100, tw_im=0x0000; input 0x0200+j0x0100 at addr 0 -> 3 cycles later out_valid=1, out=0x0200+j0x0100.
- 90° rotation: tw_re=0x0000, tw_im=0x0100; input 0x0100+j0x0000 -> out_re=0x0000, out_im=0x0100.
- Rounding: tw_re=0x0080, tw_im=0; in_re=0x0001 -> out_re=0x0001. With in_re=0xFFFF -> out_re=0x0000 (-0.5 LSB rounds up).
- Saturation: tw=0x0100+j0x0100; in=0x7FFF+j0x8000 -> out_re=0x7FFF (clipped), out_im=0xFFFF.
- Wrap and frame: 30 back-to-back samples -> tw_addr sequence 0..27,0,1. frame_done is high only with the 28th out_valid.
- Gaps, clr and reset:
  - in_valid pattern 1,0,1 -> out_valid pattern 1,0,1 with tw_addr 0,1 used.
  - clr after 5 samples -> next sample uses addr 0 and no stale out_valid appears.
  - rst_n pulsed low mid-stream -> all outputs 0 immediately, tw_addr=0.
